seq_power_sequencer: RTL

//  Parametrised next-generation CPU power/interrupt sequencer. Owns RUN/HALT/STOP/WARMUP

---
 rtl/seq_pkg.sv | 31 +++
 rtl/seq_stab_timer.sv | 36 +++
 rtl/seq_power_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and helpers for the CPU power/interrupt sequencer.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALT   = 2'd1,
        ST_STOP   = 2'd2,
        ST_WARMUP = 2'd3
    } seq_state_e;

    // Vector index width; a single source still gets a 1-bit vector.
    function automatic int unsigned vec_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Index of the lowest set bit (bit0 = highest priority); 0 when none set.
    function automatic int unsigned lowest_set(input logic [31:0] v);
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (v[i] && !found) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seq_stab_timer.sv
// Loadable saturating down-counter used for oscillator warm-up timing.
module seq_stab_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/seq_power_sequencer.sv
// CPU power/interrupt sequencer: RUN/HALT/STOP/WARMUP control, clock/oscillator
// gating, HALT-bug detection and NMI/IRQ dispatch arbitration.
module seq_power_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 5,
    parameter int unsigned STAB_W      = 16,
    parameter int unsigned STAB_CYCLES = 16'hFFFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             halt_req_i,
    input  logic                             stop_req_i,
    input  logic                             instr_end_i,
    input  logic                             ime_i,
    input  logic [NUM_IRQ-1:0]               irq_pend_i,
    input  logic                             nmi_i,
    input  logic                             wake_i,
    input  logic                             osc_stable_i,
    input  logic                             dispatch_ack_i,
    output logic                             clk_ena_o,
    output logic                             osc_ena_o,
    output logic                             dispatch_o,
    output logic                             dispatch_nmi_o,
    output logic [vec_width(NUM_IRQ)-1:0]    dispatch_vec_o,
    output logic                             halt_bug_o,
    output logic [1:0]                       state_o
);

    localparam int unsigned VW = vec_width(NUM_IRQ);

    seq_state_e    state_q, state_d;
    logic          clk_ena_q, clk_ena_d, osc_ena_q, osc_ena_d, halt_bug_q, halt_bug_d;
    logic          dispatch_q, dispatch_d, disp_nmi_q, disp_nmi_d;
    logic [VW-1:0] vec_q, vec_d;
    logic          nmi_pend_q, nmi_pend_d, nmi_s_prev_q;
    logic [2:0]    pins_raw, pins_s;
    logic          wake_s, nmi_s, osc_stable_s;
    logic          any_irq, wake_ev, nmi_rise, arb_en;
    logic          timer_zero;
    logic [STAB_W-1:0] timer_count;

    assign pins_raw = {osc_stable_i, nmi_i, wake_i};

    for (genvar g = 0; g < 3; g++) begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;
        always_ff @(posedge clk_i) begin
            if (reset_i) sync_q <= '0;
            else         sync_q <= {sync_q[SYNC_STAGES-2:0], pins_raw[g]};
        end
        assign pins_s[g] = sync_q[SYNC_STAGES-1];
    end

    assign wake_s       = pins_s[0];
    assign nmi_s        = pins_s[1];
    assign osc_stable_s = pins_s[2];
    assign any_irq      = |irq_pend_i;
    assign nmi_rise     = nmi_s & ~nmi_s_prev_q;
    assign wake_ev      = any_irq | nmi_pend_q | wake_s;

    seq_stab_timer #(.W(STAB_W)) u_stab_timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     ((state_q == ST_STOP) && (state_d == ST_WARMUP)),
        .load_val_i (STAB_W'(STAB_CYCLES - 1)),
        .dec_i      (state_q == ST_WARMUP),
        .count_o    (timer_count),
        .zero_o     (timer_zero)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (stop_req_i)                                       state_d = ST_STOP;
                else if (halt_req_i && !any_irq && !nmi_pend_q)       state_d = ST_HALT;
            end
            ST_HALT:   if (any_irq || nmi_pend_q)                     state_d = ST_RUN;
            ST_STOP:   if (wake_ev)                                   state_d = ST_WARMUP;
            ST_WARMUP: if (timer_zero && osc_stable_s)                state_d = ST_RUN;
            default:                                                  state_d = ST_RUN;
        endcase
    end

    // Enables track the next state so they change on the same edge as the state.
    always_comb begin
        clk_ena_d  = (state_d == ST_RUN);
        osc_ena_d  = (state_d != ST_STOP);
        halt_bug_d = (state_q == ST_RUN) && halt_req_i && !stop_req_i && any_irq && !ime_i;
    end

    always_comb begin
        dispatch_d = dispatch_q;
        disp_nmi_d = disp_nmi_q;
        vec_d      = vec_q;
        nmi_pend_d = nmi_pend_q;
        arb_en     = !dispatch_q &&
                     (((state_q == ST_RUN) && clk_ena_q && instr_end_i) ||
                      ((state_q == ST_HALT) && (state_d == ST_RUN)));
        if (dispatch_q && dispatch_ack_i) begin
            dispatch_d = 1'b0;
            disp_nmi_d = 1'b0;
            vec_d      = '0;
            if (disp_nmi_q) nmi_pend_d = 1'b0;
        end else if (arb_en) begin
            if (nmi_pend_q) begin
                dispatch_d = 1'b1;
                disp_nmi_d = 1'b1;
                vec_d      = '0;
            end else if (ime_i && any_irq) begin
                dispatch_d = 1'b1;
                disp_nmi_d = 1'b0;
                vec_d      = VW'(lowest_set(32'(irq_pend_i)));
            end
        end
        // A fresh edge always survives, even one coinciding with an NMI ACK.
        if (nmi_rise) nmi_pend_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_RUN;
            clk_ena_q    <= 1'b1;
            osc_ena_q    <= 1'b1;
            halt_bug_q   <= 1'b0;
            dispatch_q   <= 1'b0;
            disp_nmi_q   <= 1'b0;
            vec_q        <= '0;
            nmi_pend_q   <= 1'b0;
            nmi_s_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_ena_q    <= clk_ena_d;
            osc_ena_q    <= osc_ena_d;
            halt_bug_q   <= halt_bug_d;
            dispatch_q   <= dispatch_d;
            disp_nmi_q   <= disp_nmi_d;
            vec_q        <= vec_d;
            nmi_pend_q   <= nmi_pend_d;
            nmi_s_prev_q <= nmi_s;
        end
    end

    assign clk_ena_o      = clk_ena_q;
    assign osc_ena_o      = osc_ena_q;
    assign dispatch_o     = dispatch_q;
    assign dispatch_nmi_o = disp_nmi_q;
    assign dispatch_vec_o = vec_q;
    assign halt_bug_o     = halt_bug_q;
    assign state_o        = state_q;

endmodule
